rx_frame_packer: RTL and testbench

RX_FRAME_PACKER -- requirements
Module: rx_frame_packer

---
 rtl/nic_rx_pkg.sv | 35 +++
 rtl/rx_pipe_skid.sv | 55 +++++
 rtl/rx_frame_packer.sv | 176 +++++++++++++++++
 tb/tb_rx_frame_packer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nic_rx_pkg.sv
// Shared receive-path definitions: packed output word layout, packer FSM
// states and the default frame size limit.
package nic_rx_pkg;

  localparam int PACKED_W                = 70;
  localparam int PW_DATA_W               = 64;
  localparam int PW_DATA_LSB             = 0;
  localparam int PW_NBYTES_W             = 4;
  localparam int PW_NBYTES_LSB           = 64;
  localparam int PW_LAST_BIT             = 68;
  localparam int PW_ERR_BIT              = 69;
  localparam int MAX_FRAME_BYTES_DEFAULT = 1536;
  localparam int FRAME_CNT_W             = 11;

  typedef enum logic {
    ACCUM   = 1'b0,
    DISCARD = 1'b1
  } pack_state_e;

  function automatic logic [PACKED_W-1:0] pack_word(
    input logic                   err,
    input logic                   last,
    input logic [PW_NBYTES_W-1:0] nbytes,
    input logic [PW_DATA_W-1:0]   data
  );
    logic [PACKED_W-1:0] w;
    w                                 = '0;
    w[PW_ERR_BIT]                     = err;
    w[PW_LAST_BIT]                    = last;
    w[PW_NBYTES_LSB +: PW_NBYTES_W]   = nbytes;
    w[PW_DATA_LSB +: PW_DATA_W]       = data;
    return w;
  endfunction

endpackage

// File: rtl/rx_pipe_skid.sv
// Small circular input buffer between the upstream FIFO read pipe and the
// packer; head entry is presented from registers the cycle after a push.
module rx_pipe_skid #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic                           head_valid,
  output logic [WIDTH-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok     = pop && (count_reg != '0);
  assign head_valid = (count_reg != '0);
  assign head_data  = mem_reg[rd_ptr_reg];
  assign count      = count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= next_ptr(wr_ptr_reg);
      end
      if (pop_ok) rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rx_frame_packer.sv
// Packs byte-wide receive entries into 64-bit little-endian words with frame
// size policing. Define RX_PACK_STATS_EN to add frame/byte/oversize counters.
module rx_frame_packer
  import nic_rx_pkg::*;
#(
  parameter int MAC_WIDTH       = 8,
  parameter int NIC_WIDTH       = 10,
  parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NIC_WIDTH-1:0] RX_FIFO_pipe_read_data,
  output logic                 RX_FIFO_pipe_read_req,
  input  logic                 RX_FIFO_pipe_read_ack,
  output logic [PACKED_W-1:0]  RX_PACKED_pipe_write_data,
  output logic                 RX_PACKED_pipe_write_req,
  input  logic                 RX_PACKED_pipe_write_ack
`ifdef RX_PACK_STATS_EN
  ,
  output logic [31:0]          frame_count,
  output logic [31:0]          byte_count,
  output logic [15:0]          oversize_count
`endif
);

  localparam int LANES     = PW_DATA_W / MAC_WIDTH;
  localparam int BUF_DEPTH = 3;

  logic                    in_flight_reg;
  logic                    head_valid;
  logic [NIC_WIDTH-1:0]    head_data;
  logic [1:0]              buf_count;
  logic                    pop;

  pack_state_e             state_reg;
  logic [PW_DATA_W-1:0]    acc_data_reg;
  logic [PW_NBYTES_W-1:0]  acc_cnt_reg;
  logic [FRAME_CNT_W-1:0]  frame_bytes_reg;
  logic                    out_valid_reg;
  logic [PACKED_W-1:0]     out_data_reg;

  logic                    head_last;
  logic                    head_keep;
  logic [MAC_WIDTH-1:0]    head_byte;
  logic [PW_DATA_W-1:0]    merged_data;
  logic                    closes;
  logic                    over_limit;
  logic                    out_accept;
  logic                    out_free;

  rx_pipe_skid #(
    .WIDTH (NIC_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (in_flight_reg),
    .push_data  (RX_FIFO_pipe_read_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (buf_count)
  );

  // Entry layout is {tlast, tdata, tkeep}.
  assign head_last = head_data[NIC_WIDTH-1];
  assign head_byte = head_data[MAC_WIDTH:1];
  assign head_keep = head_data[0];

  // Counting in-flight reads keeps the buffer from ever overflowing.
  assign RX_FIFO_pipe_read_req = !reset &&
      (({1'b0, buf_count} + {2'b00, in_flight_reg}) < 3'(BUF_DEPTH));

  assign RX_PACKED_pipe_write_req  = out_valid_reg && !reset;
  assign RX_PACKED_pipe_write_data = reset ? '0 : out_data_reg;

  assign out_accept = RX_PACKED_pipe_write_req && RX_PACKED_pipe_write_ack;
  assign out_free   = !out_valid_reg || out_accept;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign merged_data[gi*MAC_WIDTH +: MAC_WIDTH] =
          (acc_cnt_reg == PW_NBYTES_W'(gi)) ? head_byte
                                            : acc_data_reg[gi*MAC_WIDTH +: MAC_WIDTH];
    end
  endgenerate

  assign closes     = head_last || (head_keep && (acc_cnt_reg == PW_NBYTES_W'(LANES-1)));
  assign over_limit = head_keep &&
      (({1'b0, frame_bytes_reg} + 12'd1) > 12'(MAX_FRAME_BYTES));

  // An entry that would produce an output word waits for a free output slot.
  always_comb begin
    pop = 1'b0;
    if (head_valid) begin
      if (state_reg == DISCARD || over_limit) pop = !head_last || out_free;
      else                                    pop = !closes || out_free;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ACCUM;
      in_flight_reg   <= 1'b0;
      acc_data_reg    <= '0;
      acc_cnt_reg     <= '0;
      frame_bytes_reg <= '0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
    end else begin
      in_flight_reg <= RX_FIFO_pipe_read_req && RX_FIFO_pipe_read_ack;
      if (out_accept) out_valid_reg <= 1'b0;
      if (pop) begin
        case (state_reg)
          ACCUM: begin
            if (over_limit) begin
              acc_data_reg    <= '0;
              acc_cnt_reg     <= '0;
              frame_bytes_reg <= '0;
              if (head_last) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= pack_word(1'b1, 1'b1, 4'd0, 64'd0);
              end else begin
                state_reg <= DISCARD;
              end
            end else if (closes) begin
              out_valid_reg <= 1'b1;
              out_data_reg  <= head_keep
                  ? pack_word(1'b0, head_last, acc_cnt_reg + 4'd1, merged_data)
                  : pack_word(1'b0, 1'b1, acc_cnt_reg, acc_data_reg);
              acc_data_reg    <= '0;
              acc_cnt_reg     <= '0;
              frame_bytes_reg <= head_last ? '0 : frame_bytes_reg + FRAME_CNT_W'(head_keep);
            end else if (head_keep) begin
              acc_data_reg    <= merged_data;
              acc_cnt_reg     <= acc_cnt_reg + 4'd1;
              frame_bytes_reg <= frame_bytes_reg + 1'b1;
            end
          end
          DISCARD: begin
            if (head_last) begin
              out_valid_reg   <= 1'b1;
              out_data_reg    <= pack_word(1'b1, 1'b1, 4'd0, 64'd0);
              frame_bytes_reg <= '0;
              state_reg       <= ACCUM;
            end
          end
        endcase
      end
    end
  end

`ifdef RX_PACK_STATS_EN
  logic [31:0] frame_count_reg;
  logic [31:0] byte_count_reg;
  logic [15:0] oversize_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_reg    <= '0;
      byte_count_reg     <= '0;
      oversize_count_reg <= '0;
    end else if (out_accept) begin
      frame_count_reg    <= frame_count_reg + 32'(out_data_reg[PW_LAST_BIT]);
      byte_count_reg     <= byte_count_reg + 32'(out_data_reg[PW_NBYTES_LSB +: PW_NBYTES_W]);
      oversize_count_reg <= oversize_count_reg + 16'(out_data_reg[PW_ERR_BIT]);
    end
  end

  assign frame_count    = frame_count_reg;
  assign byte_count     = byte_count_reg;
  assign oversize_count = oversize_count_reg;
`endif

endmodule

// File: tb/tb_rx_frame_packer.sv
// Self-checking bench for rx_frame_packer: directed frames plus randomized
// frames checked against a frame-level packing model.
module tb_rx_frame_packer;

  localparam int MAXB = 1536;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  read_data;
  logic        read_req;
  logic        read_ack;
  logic [69:0] write_data;
  logic        write_req;
  logic        write_ack;

`ifdef RX_PACK_STATS_EN
  logic [31:0] frame_count;
  logic [31:0] byte_count;
  logic [15:0] oversize_count;
`endif

  rx_frame_packer dut (
    .clk                       (clk),
    .reset                     (reset),
    .RX_FIFO_pipe_read_data    (read_data),
    .RX_FIFO_pipe_read_req     (read_req),
    .RX_FIFO_pipe_read_ack     (read_ack),
    .RX_PACKED_pipe_write_data (write_data),
    .RX_PACKED_pipe_write_req  (write_req),
    .RX_PACKED_pipe_write_ack  (write_ack)
`ifdef RX_PACK_STATS_EN
    ,
    .frame_count               (frame_count),
    .byte_count                (byte_count),
    .oversize_count            (oversize_count)
`endif
  );

  always #5 clk = ~clk;

  logic [9:0]  up_q[$];
  logic [69:0] exp_q[$];
  logic [7:0]  kb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int up_mode = 0;
  int wack_mode = 0;
  int n_extra = 0;
  int last_xfer_cyc = -100;
  int rise_cyc = -1;
  bit xfer_prev = 0;
  bit stall_prev = 0;
  bit wreq_prev = 0;
  bit saw_rreq_low = 0;
  logic [69:0] held_data;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [69:0] mkword(bit err, bit last, int nb, logic [63:0] d);
    return {err, last, 4'(nb), d};
  endfunction

  // Upstream FIFO model and downstream sink, both acting mid-cycle.
  always @(negedge clk) begin
    if (xfer_prev) read_data = up_q.pop_front();
    else           read_data = 10'($urandom);
    xfer_prev = 0;
    read_ack = (up_q.size() > 0) && (up_mode == 0 || $urandom_range(0, 3) != 0);
    if (read_req && read_ack) begin
      xfer_prev = 1;
      if (up_q[0][9]) last_xfer_cyc = cyc;
    end
    if (!reset && !read_req) saw_rreq_low = 1;

    if (stall_prev && !reset) begin
      check("hold_req", 70'(write_req), 70'd1);
      check("hold_data", write_data, held_data);
    end
    case (wack_mode)
      0:       write_ack = 1'b1;
      1:       write_ack = ($urandom_range(0, 2) != 0);
      default: write_ack = 1'b0;
    endcase
    if (write_req && !wreq_prev) rise_cyc = cyc;
    wreq_prev = write_req;
    if (write_req && write_ack) begin
      if (exp_q.size() == 0) n_extra++;
      else check("word", write_data, exp_q.pop_front());
    end
    stall_prev = write_req && !write_ack && !reset;
    held_data  = write_data;
  end

  // Expected words for the kept bytes of one frame held in kb_q.
  task automatic model_expect(input bit empty_tail);
    int n, full, rem;
    logic [63:0] d;
    n = kb_q.size();
    if (n > MAXB) begin
      for (int w = 0; w < MAXB / 8; w++) begin
        d = '0;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = kb_q[w*8+i];
        exp_q.push_back(mkword(0, 0, 8, d));
      end
      exp_q.push_back(mkword(1, 1, 0, 64'd0));
    end else begin
      full = n / 8;
      rem  = n % 8;
      for (int w = 0; w < full; w++) begin
        d = '0;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = kb_q[w*8+i];
        exp_q.push_back(mkword(0, (w == full-1) && rem == 0 && !empty_tail, 8, d));
      end
      if (rem != 0 || empty_tail) begin
        d = '0;
        for (int i = 0; i < rem; i++) d[i*8 +: 8] = kb_q[full*8+i];
        exp_q.push_back(mkword(0, 1, rem, d));
      end
    end
    kb_q.delete();
  endtask

  task automatic enqueue_frame(input int n, input bit zero_tail, input int hole_pct);
    bit zt;
    logic [7:0] b;
    zt = zero_tail || (n == 0);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < hole_pct) up_q.push_back({1'b0, 8'($urandom), 1'b0});
      b = 8'($urandom);
      up_q.push_back({(i == n-1) && !zt, b, 1'b1});
      kb_q.push_back(b);
    end
    if (zt) up_q.push_back({1'b1, 8'($urandom), 1'b0});
    model_expect(zt);
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0 || xfer_prev) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_pending"}, 70'(exp_q.size()), 70'd0);
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_extra"}, 70'(n_extra), 70'd0);
    n_extra = 0;
  endtask

  initial begin
    logic [63:0] d;
    int k;
    reset = 1'b1; read_data = '0; read_ack = 1'b0; write_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_req", 70'(read_req), 70'd0);
    check("rst_write_req", 70'(write_req), 70'd0);
    check("rst_write_data", write_data, 70'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_write_req", 70'(write_req), 70'd0);

    // 8 bytes, tlast on the 8th: one full word three cycles after the last transfer
    for (int i = 0; i < 8; i++) up_q.push_back({i == 7, 8'(i+1), 1'b1});
    exp_q.push_back(mkword(0, 1, 8, 64'h0807060504030201));
    drain("full8", 200);
    check("t3_latency", 70'(rise_cyc), 70'(last_xfer_cyc + 3));
    $display("[TB] txn full8: rise_cyc=%0d last_xfer_cyc=%0d", rise_cyc, last_xfer_cyc);

    // 11-byte frame
    for (int i = 0; i < 11; i++) up_q.push_back({i == 10, 8'(8'h11 + i), 1'b1});
    exp_q.push_back(mkword(0, 0, 8, 64'h1817161514131211));
    exp_q.push_back(mkword(0, 1, 3, 64'h00000000001B1A19));
    drain("len11", 200);
    $display("[TB] txn len11 done");

    // Downstream backpressure for 20 cycles mid-frame
    wack_mode = 2;
    enqueue_frame(40, 0, 0);
    k = 0;
    while (!write_req && k < 200) begin @(posedge clk); #1; k++; end
    check("bp_wreq_seen", 70'(write_req), 70'd1);
    saw_rreq_low = 0;
    repeat (20) @(posedge clk);
    #1;
    check("bp_rreq_fell", 70'(saw_rreq_low), 70'd1);
    wack_mode = 0;
    drain("backpressure", 500);
    $display("[TB] txn backpressure done");

    // tlast on a tkeep=0 entry after 5 bytes
    for (int i = 0; i < 5; i++) up_q.push_back({1'b0, 8'(8'hA1 + i), 1'b1});
    up_q.push_back({1'b1, 8'h5A, 1'b0});
    exp_q.push_back(mkword(0, 1, 5, 64'h000000A5A4A3A2A1));
    drain("keep0_tlast", 200);
    $display("[TB] txn keep0_tlast done");

    // 1600-byte oversize frame followed by a normal frame
    for (int i = 0; i < 1600; i++) up_q.push_back({i == 1599, 8'(i*7+3), 1'b1});
    for (int w = 0; w < 192; w++) begin
      d = '0;
      for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'((w*8+j)*7+3);
      exp_q.push_back(mkword(0, 0, 8, d));
    end
    exp_q.push_back(mkword(1, 1, 0, 64'd0));
    enqueue_frame(13, 0, 0);
    drain("oversize", 5000);
    $display("[TB] txn oversize done");

    // Reset in the middle of a frame with a word held in the output register
    wack_mode = 2;
    for (int i = 0; i < 11; i++) up_q.push_back({1'b0, 8'(8'h50 + i), 1'b1});
    k = 0;
    while ((up_q.size() != 0 || xfer_prev) && k < 100) begin @(posedge clk); #1; k++; end
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_wreq", 70'(write_req), 70'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_read_req", 70'(read_req), 70'd0);
    check("midrst_write_req", 70'(write_req), 70'd0);
    check("midrst_write_data", write_data, 70'd0);
    reset = 1'b0;
    wack_mode = 0;
    enqueue_frame(10, 0, 0);
    drain("after_reset", 300);
    $display("[TB] txn after_reset done");

    // Randomized frames with upstream gaps, tkeep holes and random backpressure
    up_mode = 1;
    wack_mode = 1;
    for (int f = 0; f < 40; f++) begin
      enqueue_frame(($urandom_range(0, 3) == 0) ? $urandom_range(17, 40) : $urandom_range(0, 16),
                    $urandom_range(0, 3) == 0, 15);
    end
    drain("random", 8000);
    $display("[TB] txn random done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
